// File: rtl/core_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM state
// encoding, latency limits and a saturating counter helper.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mas_state_e;

  localparam int unsigned MEM_LATENCY_MAX = 15;
  localparam int unsigned LAT_CNT_WIDTH   = $clog2(MEM_LATENCY_MAX + 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundles the upstream handshake/payload, downstream handshake/payload and
// data-memory bus of mem_access_stage. slave = stage side, master = environment.
interface mem_access_stage_if #(
  parameter int unsigned PC_WIDTH   = 5,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SB_WIDTH   = 40
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_aorf_result;
  logic [31:0]           alu_result;
  logic [31:0]           fpu_result;
  logic [31:0]           store_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [SB_WIDTH-1:0]   in_sb;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [PC_WIDTH-1:0]   in_pc1;
  logic [PC_WIDTH-1:0]   in_pc2;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [31:0]           mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_result;
  logic [31:0]           out_read_data;
  logic [31:0]           out_store_data;
  logic [SB_WIDTH-1:0]   out_sb;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [PC_WIDTH-1:0]   out_pc1;
  logic [PC_WIDTH-1:0]   out_pc2;

  modport slave (
    input  in_valid, in_aorf_result, alu_result, fpu_result, store_data,
           mem_read, mem_write, in_sb, in_pc, in_pc1, in_pc2,
           mem_rdata, out_ready,
    output in_ready, mem_addr, mem_wdata, mem_we, mem_re,
           out_valid, out_result, out_read_data, out_store_data,
           out_sb, out_pc, out_pc1, out_pc2
  );

  modport master (
    output in_valid, in_aorf_result, alu_result, fpu_result, store_data,
           mem_read, mem_write, in_sb, in_pc, in_pc1, in_pc2,
           mem_rdata, out_ready,
    input  in_ready, mem_addr, mem_wdata, mem_we, mem_re,
           out_valid, out_result, out_read_data, out_store_data,
           out_sb, out_pc, out_pc1, out_pc2
  );
endinterface

// File: rtl/mem_access_stage_lat_counter.sv
// Load-latency down-counter: loadable, decrements toward zero, flags zero.
module mem_lat_counter
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = LAT_CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: selects ALU/FPU result as address, issues
// loads/stores to an external data memory, waits MEM_LATENCY cycles for load
// data and presents one registered result downstream with valid/ready.
// Optional macro MEM_ACCESS_PERF_EN adds perf_load_cnt / perf_stall_cnt.
module mem_access_stage
  import core_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 5,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SB_WIDTH    = 40,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic CLK,
  input  logic reset,
  mem_access_stage_if.slave bus
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] perf_load_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(MEM_LATENCY - 1);

  mas_state_e state_q, state_d;

  logic [31:0] result;
  logic        in_ready;
  logic        accept;
  logic        take_direct;
  logic        take_pending;
  logic        capture;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  logic                out_valid_q;
  logic [31:0]         out_result_q;
  logic [31:0]         out_read_data_q;
  logic [31:0]         out_store_data_q;
  logic [SB_WIDTH-1:0] out_sb_q;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc1_q, out_pc2_q;

  logic [31:0]         pend_result_q;
  logic [31:0]         pend_store_data_q;
  logic [SB_WIDTH-1:0] pend_sb_q;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc1_q, pend_pc2_q;

  assign result   = bus.in_aorf_result ? bus.fpu_result : bus.alu_result;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath steering; read wins when both mem_read and mem_write are set.
  always_comb begin
    state_d      = state_q;
    take_direct  = 1'b0;
    take_pending = 1'b0;
    capture      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.mem_read) begin
            take_pending = 1'b1;
            cnt_load     = 1'b1;
            state_d      = WAIT;
          end else begin
            take_direct = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_lat_counter #(
    .WIDTH (LAT_CNT_WIDTH)
  ) u_lat_cnt (
    .CLK      (CLK),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Pending payload for the single outstanding load.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pend_result_q     <= '0;
      pend_store_data_q <= '0;
      pend_sb_q         <= '0;
      pend_pc_q         <= '0;
      pend_pc1_q        <= '0;
      pend_pc2_q        <= '0;
    end else if (take_pending) begin
      pend_result_q     <= result;
      pend_store_data_q <= bus.store_data;
      pend_sb_q         <= bus.in_sb;
      pend_pc_q         <= bus.in_pc;
      pend_pc1_q        <= bus.in_pc1;
      pend_pc2_q        <= bus.in_pc2;
    end
  end

  // Output register: a new word can replace a draining one in the same cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_read_data_q  <= '0;
      out_store_data_q <= '0;
      out_sb_q         <= '0;
      out_pc_q         <= '0;
      out_pc1_q        <= '0;
      out_pc2_q        <= '0;
    end else if (take_direct) begin
      out_valid_q      <= 1'b1;
      out_result_q     <= result;
      out_store_data_q <= bus.store_data;
      out_sb_q         <= bus.in_sb;
      out_pc_q         <= bus.in_pc;
      out_pc1_q        <= bus.in_pc1;
      out_pc2_q        <= bus.in_pc2;
    end else if (capture) begin
      out_valid_q      <= 1'b1;
      out_result_q     <= pend_result_q;
      out_read_data_q  <= bus.mem_rdata;
      out_store_data_q <= pend_store_data_q;
      out_sb_q         <= pend_sb_q;
      out_pc_q         <= pend_pc_q;
      out_pc1_q        <= pend_pc1_q;
      out_pc2_q        <= pend_pc2_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.mem_addr       = result[ADDR_WIDTH-1:0];
  assign bus.mem_wdata      = bus.store_data;
  assign bus.mem_re         = !reset && accept && bus.mem_read;
  assign bus.mem_we         = !reset && accept && bus.mem_write && !bus.mem_read;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_read_data  = out_read_data_q;
  assign bus.out_store_data = out_store_data_q;
  assign bus.out_sb         = out_sb_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_pc1        = out_pc1_q;
  assign bus.out_pc2        = out_pc2_q;

`ifdef MEM_ACCESS_PERF_EN
  // Saturating counters of accepted loads and downstream back-pressure cycles.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      perf_load_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (take_pending) begin
        perf_load_cnt <= sat_inc32(perf_load_cnt);
      end
      if (out_valid_q && !bus.out_ready) begin
        perf_stall_cnt <= sat_inc32(perf_stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver pushes expected outputs,
// a negedge monitor pops and compares on each downstream handshake.
module tb_mem_access_stage;

  localparam int unsigned PCW = 5;
  localparam int unsigned AW  = 32;
  localparam int unsigned SBW = 40;
  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0]    result;
    logic [31:0]    rd;
    logic [31:0]    sd;
    logic [SBW-1:0] sb;
    logic [PCW-1:0] pc, pc1, pc2;
    int             first;
  } exp_t;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int          rd_due = -1;
  logic [31:0] rd_val = '0;

  mem_access_stage_if #(.PC_WIDTH(PCW), .ADDR_WIDTH(AW), .SB_WIDTH(SBW)) bus ();

`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] perf_load_cnt, perf_stall_cnt;
`endif

  mem_access_stage #(
    .PC_WIDTH    (PCW),
    .ADDR_WIDTH  (AW),
    .SB_WIDTH    (SBW),
    .MEM_LATENCY (LAT)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ACCESS_PERF_EN
    ,
    .perf_load_cnt  (perf_load_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Data memory model: responds LAT cycles after a read request, garbage otherwise.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], 16'hA5A5};
  endfunction

  always @(negedge CLK) begin
    if (bus.mem_re) begin
      rd_due = cyc + LAT;
      rd_val = mem_word(bus.mem_addr);
    end
  end

  always @(posedge CLK) begin
    #1;
    bus.mem_rdata = (cyc == rd_due) ? rd_val : 32'hBAD0BAD0;
  end

  // Monitor: pop and compare on every downstream handshake.
  bit seen = 0;
  int first_cyc = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      seen = 0;
    end else begin
      if (bus.out_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h with empty scoreboard (cycle %0d)",
                   bus.out_result, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("out_result", 64'(bus.out_result), 64'(e.result));
          chk("out_read_data", 64'(bus.out_read_data), 64'(e.rd));
          chk("out_store_data", 64'(bus.out_store_data), 64'(e.sd));
          chk("out_sb", 64'(bus.out_sb), 64'(e.sb));
          chk("out_pcs", 64'({bus.out_pc, bus.out_pc1, bus.out_pc2}),
              64'({e.pc, e.pc1, e.pc2}));
          chk("latency", 64'(first_cyc), 64'(e.first));
        end
        seen = 0;
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_aorf_result = 1'b0;
    bus.alu_result     = '0;
    bus.fpu_result     = '0;
    bus.store_data     = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.in_sb          = '0;
    bus.in_pc          = '0;
    bus.in_pc1         = '0;
    bus.in_pc2         = '0;
  endtask

  // Present one op, wait (bounded) for accept, check memory strobes, push expectation.
  task automatic send(input logic aorf, input logic [31:0] alu, input logic [31:0] fpu,
                      input logic [31:0] sd, input logic mr, input logic mw,
                      input logic [SBW-1:0] sbv, input logic [PCW-1:0] p0,
                      input logic [PCW-1:0] p1, input logic [PCW-1:0] p2,
                      input logic [31:0] exp_res, input logic [31:0] exp_rd);
    exp_t e;
    bit ok = 0;
    bus.in_valid       = 1'b1;
    bus.in_aorf_result = aorf;
    bus.alu_result     = alu;
    bus.fpu_result     = fpu;
    bus.store_data     = sd;
    bus.mem_read       = mr;
    bus.mem_write      = mw;
    bus.in_sb          = sbv;
    bus.in_pc          = p0;
    bus.in_pc1         = p1;
    bus.in_pc2         = p2;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 expected 1 within 50 cycles");
    end else begin
      chk("mem_addr", 64'(bus.mem_addr), 64'(exp_res));
      chk("mem_re", 64'(bus.mem_re), 64'(mr));
      chk("mem_we", 64'(bus.mem_we), 64'(mw && !mr));
      if (mw && !mr) chk("mem_wdata", 64'(bus.mem_wdata), 64'(sd));
      e.result = exp_res;
      e.rd     = exp_rd;
      e.sd     = sd;
      e.sb     = sbv;
      e.pc     = p0;
      e.pc1    = p1;
      e.pc2    = p2;
      e.first  = cyc + (mr ? int'(LAT) + 1 : 1);
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [31:0] stall_base;
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.mem_rdata = '0;

    // Reset state with a load/store request held on the inputs.
    bus.in_valid  = 1'b1;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_re", 64'(bus.mem_re), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    idle_inputs();
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;

    // ALU op.
    send(1'b0, 32'h10, 32'h99, 32'h0, 1'b0, 1'b0, 40'h11_2233_4455, 5'd1, 5'd2, 5'd3,
         32'h10, 32'h0);
    // Load via FPU result at 0x40.
    send(1'b1, 32'h123, 32'h40, 32'h7, 1'b1, 1'b0, 40'hAA_0000_0001, 5'd4, 5'd5, 5'd6,
         32'h40, 32'hDEADBEEF);
    // Store to 0x8; read data must hold the previous load value.
    send(1'b0, 32'h8, 32'h0, 32'h55, 1'b0, 1'b1, 40'h00_0000_0002, 5'd7, 5'd8, 5'd9,
         32'h8, 32'hDEADBEEF);
    @(negedge CLK);
    chk("store_we_after", 64'(bus.mem_we), 64'd0);
    chk("store_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1;

    // Back-to-back ALU ops: accept while draining.
    send(1'b1, 32'h1, 32'h77, 32'h3, 1'b0, 1'b0, 40'h01_0203_0405, 5'd10, 5'd11, 5'd12,
         32'h77, 32'hDEADBEEF);
    send(1'b0, 32'hABCD, 32'h2, 32'h4, 1'b0, 1'b0, 40'hFF_FFFF_FFFF, 5'd31, 5'd0, 5'd17,
         32'hABCD, 32'hDEADBEEF);

    // mem_read and mem_write both set: load, never a write strobe.
    send(1'b0, 32'h20, 32'h0, 32'h99, 1'b1, 1'b1, 40'h12_3456_789A, 5'd13, 5'd14, 5'd15,
         32'h20, 32'h0020A5A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("both_no_we", 64'(bus.mem_we), 64'd0);
    end
    @(posedge CLK);
    #1;

    // Load followed by 4 cycles of back-pressure.
    bus.out_ready = 1'b0;
    send(1'b0, 32'h30, 32'h0, 32'h66, 1'b1, 1'b0, 40'h0F_0E0D_0C0B, 5'd16, 5'd18, 5'd19,
         32'h30, 32'h0030A5A5);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        got = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("stall_valid_seen", 64'(got), 64'd1);
`ifdef MEM_ACCESS_PERF_EN
    stall_base = perf_stall_cnt;
    chk("perf_load_cnt", 64'(perf_load_cnt), 64'd3);
`else
    stall_base = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_result", 64'(bus.out_result), 64'h30);
      chk("stall_read_data", 64'(bus.out_read_data), 64'h0030A5A5);
    end
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
`ifdef MEM_ACCESS_PERF_EN
    chk("perf_stall_cnt", 64'(perf_stall_cnt - stall_base), 64'd4);
`endif
    @(posedge CLK);
    #1;

    // Reset while the load is in WAIT: aborted, never presented.
    send(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 40'h55_5555_5555, 5'd20, 5'd21, 5'd22,
         32'h40, 32'hDEADBEEF);
    reset = 1'b1;
    void'(sb_q.pop_back());
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_result", 64'(bus.out_result), 64'd0);
    chk("abort_read_data", 64'(bus.out_read_data), 64'd0);
    bus.in_valid  = 1'b1;
    bus.mem_write = 1'b1;
    @(negedge CLK);
    chk("abort_mem_we", 64'(bus.mem_we), 64'd0);
    chk("abort_mem_re", 64'(bus.mem_re), 64'd0);
    idle_inputs();
    @(negedge CLK);
    reset = 1'b0;
    repeat (6) @(posedge CLK);
    #1;

    // After reset the held read data is zero.
    send(1'b0, 32'h5A5A, 32'h0, 32'h1, 1'b0, 1'b0, 40'h00_0000_00FF, 5'd23, 5'd24, 5'd25,
         32'h5A5A, 32'h0);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
